// File: rtl/quote_scheduler.sv
// Quote scheduler: round-robin intake of three exchange feeds into a price table,
// dispatch of complete (dirty) stocks to an external arbitrage engine, order handshake.
module quote_scheduler #(
    parameter int unsigned ENG_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fa_valid,
    input  logic        fb_valid,
    input  logic        fc_valid,
    output logic        fa_ready,
    output logic        fb_ready,
    output logic        fc_ready,
    input  logic [1:0]  fa_stock,
    input  logic [1:0]  fb_stock,
    input  logic [1:0]  fc_stock,
    input  logic [15:0] fa_price,
    input  logic [15:0] fb_price,
    input  logic [15:0] fc_price,
    output logic [1:0]  eng_stock_id,
    output logic [15:0] eng_price_a,
    output logic [15:0] eng_price_b,
    output logic [15:0] eng_price_c,
    input  logic [1:0]  eng_action_a,
    input  logic [1:0]  eng_action_b,
    input  logic [1:0]  eng_action_c,
    output logic        ord_valid,
    input  logic        ord_ready,
    output logic [1:0]  ord_stock,
    output logic [1:0]  ord_action_a,
    output logic [1:0]  ord_action_b,
    output logic [1:0]  ord_action_c,
    output logic [15:0] ord_count
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, OUTPUT} state_t;

    state_t state, state_next;

    logic [3:0][2:0][15:0] price_tbl;
    logic [3:0][2:0]       have_tbl;
    logic [3:0]            dirty;
    logic [1:0]            feed_ptr;
    logic [1:0]            stock_ptr;
    logic [2:0]            wait_cnt;

    logic [2:0]  grant;
    logic [1:0]  grant_idx;
    logic        accept;
    logic [1:0]  acc_stock;
    logic [15:0] acc_price;
    logic [2:0]  have_after;
    logic [3:0]  set_mask;
    logic [3:0]  clr_mask;

    logic        sel_found;
    logic [1:0]  sel_stock;
    logic        load_eng;
    logic        capture;
    logic        handshake;
    logic        all_hold;
    logic        wait_done;

    // Round-robin grant starting at feed_ptr; suppressed while reset is held.
    always_comb begin
        grant = '0;
        case (feed_ptr)
            2'd1:    grant = fb_valid ? 3'b010 : fc_valid ? 3'b100 : fa_valid ? 3'b001 : 3'b000;
            2'd2:    grant = fc_valid ? 3'b100 : fa_valid ? 3'b001 : fb_valid ? 3'b010 : 3'b000;
            default: grant = fa_valid ? 3'b001 : fb_valid ? 3'b010 : fc_valid ? 3'b100 : 3'b000;
        endcase
        if (reset) begin
            grant = '0;
        end
    end

    assign fa_ready  = grant[0];
    assign fb_ready  = grant[1];
    assign fc_ready  = grant[2];
    assign accept    = |grant;
    assign grant_idx = grant[2] ? 2'd2 : grant[1] ? 2'd1 : 2'd0;

    always_comb begin
        acc_stock = fa_stock;
        acc_price = fa_price;
        case (grant_idx)
            2'd1: begin
                acc_stock = fb_stock;
                acc_price = fb_price;
            end
            2'd2: begin
                acc_stock = fc_stock;
                acc_price = fc_price;
            end
            default: ;
        endcase
    end

    assign have_after = have_tbl[acc_stock] | (3'b001 << grant_idx);
    assign set_mask   = (accept && (&have_after)) ? (4'b0001 << acc_stock) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            price_tbl <= '0;
            have_tbl  <= '0;
            feed_ptr  <= '0;
        end else if (accept) begin
            price_tbl[acc_stock][grant_idx] <= acc_price;
            have_tbl[acc_stock][grant_idx]  <= 1'b1;
            feed_ptr                        <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
        end
    end

    // Lowest dirty stock at or after stock_ptr, wrapping through the 2-bit index.
    always_comb begin
        sel_found = 1'b0;
        sel_stock = stock_ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!sel_found && dirty[stock_ptr + 2'(i)]) begin
                sel_found = 1'b1;
                sel_stock = stock_ptr + 2'(i);
            end
        end
    end

    assign all_hold  = (eng_action_a == 2'b00) && (eng_action_b == 2'b00) && (eng_action_c == 2'b00);
    assign wait_done = (wait_cnt == 3'(ENG_LATENCY - 1));

    always_comb begin
        state_next = state;
        clr_mask   = '0;
        load_eng   = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    clr_mask   = 4'b0001 << sel_stock;
                    load_eng   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (wait_done) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                capture    = 1'b1;
                state_next = all_hold ? IDLE : OUTPUT;
            end
            OUTPUT: begin
                if (ord_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ord_valid = (state == OUTPUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
        end
    end

    // A fresh quote's set wins over the IDLE selection's clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty <= '0;
        end else begin
            dirty <= (dirty & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_stock_id <= '0;
            eng_price_a  <= '0;
            eng_price_b  <= '0;
            eng_price_c  <= '0;
        end else if (load_eng) begin
            eng_stock_id <= sel_stock;
            eng_price_a  <= price_tbl[sel_stock][0];
            eng_price_b  <= price_tbl[sel_stock][1];
            eng_price_c  <= price_tbl[sel_stock][2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ord_stock    <= '0;
            ord_action_a <= '0;
            ord_action_b <= '0;
            ord_action_c <= '0;
            ord_count    <= '0;
            stock_ptr    <= '0;
        end else begin
            if (capture) begin
                ord_stock    <= eng_stock_id;
                ord_action_a <= eng_action_a;
                ord_action_b <= eng_action_b;
                ord_action_c <= eng_action_c;
            end
            if ((capture && all_hold) || handshake) begin
                stock_ptr <= eng_stock_id + 2'd1;
            end
            if (handshake && (ord_count != 16'hFFFF)) begin
                ord_count <= ord_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_quote_scheduler.sv
// Bench for quote_scheduler: directed scenarios plus a random soak, all checked
// cycle by cycle against a transaction-level model of feeds, table and dispatch.
module tb_quote_scheduler;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fa_valid = 1'b0, fb_valid = 1'b0, fc_valid = 1'b0;
    logic        fa_ready, fb_ready, fc_ready;
    logic [1:0]  fa_stock = '0, fb_stock = '0, fc_stock = '0;
    logic [15:0] fa_price = '0, fb_price = '0, fc_price = '0;
    logic [1:0]  eng_stock_id;
    logic [15:0] eng_price_a, eng_price_b, eng_price_c;
    logic [1:0]  eng_action_a, eng_action_b, eng_action_c;
    logic        ord_valid;
    logic        ord_ready = 1'b0;
    logic [1:0]  ord_stock, ord_action_a, ord_action_b, ord_action_c;
    logic [15:0] ord_count;

    int n_checks = 0;
    int n_errors = 0;

    quote_scheduler #(.ENG_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .fa_valid(fa_valid), .fb_valid(fb_valid), .fc_valid(fc_valid),
        .fa_ready(fa_ready), .fb_ready(fb_ready), .fc_ready(fc_ready),
        .fa_stock(fa_stock), .fb_stock(fb_stock), .fc_stock(fc_stock),
        .fa_price(fa_price), .fb_price(fb_price), .fc_price(fc_price),
        .eng_stock_id(eng_stock_id),
        .eng_price_a(eng_price_a), .eng_price_b(eng_price_b), .eng_price_c(eng_price_c),
        .eng_action_a(eng_action_a), .eng_action_b(eng_action_b), .eng_action_c(eng_action_c),
        .ord_valid(ord_valid), .ord_ready(ord_ready),
        .ord_stock(ord_stock),
        .ord_action_a(ord_action_a), .ord_action_b(ord_action_b), .ord_action_c(ord_action_c),
        .ord_count(ord_count)
    );

    always #5 clk = ~clk;

    // Engine: SELL on the highest price, BUY on the lowest, HOLD otherwise or when all equal.
    function automatic logic [5:0] engine(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        logic [15:0] mx, mn;
        logic [1:0]  r [3];
        logic [15:0] p [3];
        p[0] = a; p[1] = b; p[2] = c;
        mx = a; mn = a;
        for (int i = 1; i < 3; i++) begin
            if (p[i] > mx) mx = p[i];
            if (p[i] < mn) mn = p[i];
        end
        for (int i = 0; i < 3; i++) begin
            if (mx == mn)      r[i] = 2'b00;
            else if (p[i] == mx) r[i] = 2'b10;
            else if (p[i] == mn) r[i] = 2'b01;
            else               r[i] = 2'b00;
        end
        return {r[0], r[1], r[2]};
    endfunction

    assign {eng_action_a, eng_action_b, eng_action_c} = engine(eng_price_a, eng_price_b, eng_price_c);

    // Reference model state
    logic [15:0] m_price [4][3];
    bit          m_have  [4][3];
    bit   [3:0]  m_dirty;
    int          m_rr, m_sptr, m_sel, m_age, m_count;
    bit          m_busy, m_out;
    logic [47:0] m_snap;
    logic [5:0]  m_act;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++)
            for (int e = 0; e < 3; e++) begin
                m_price[s][e] = '0;
                m_have[s][e]  = 1'b0;
            end
        m_dirty = '0; m_rr = 0; m_sptr = 0; m_sel = 0; m_age = 0; m_count = 0;
        m_busy = 1'b0; m_out = 1'b0; m_snap = '0; m_act = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        fa_valid = 1'b1; fb_valid = 1'b1; fc_valid = 1'b1;
        ord_ready = 1'b1;
        #1;
        check_eq("rst_ready", {fc_ready, fb_ready, fa_ready}, 3'b000);
        check_eq("rst_ord_valid", ord_valid, 1'b0);
        check_eq("rst_ord_count", ord_count, 16'd0);
        check_eq("rst_eng", {eng_stock_id, eng_price_a, eng_price_b, eng_price_c}, '0);
        check_eq("rst_ord", {ord_stock, ord_action_a, ord_action_b, ord_action_c}, '0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        fa_valid = 1'b0; fb_valid = 1'b0; fc_valid = 1'b0;
    endtask

    // One clock: drive inputs, check the DUT against the model, then advance the model.
    task automatic tick(input logic [2:0] v, input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] sc,
                        input logic [15:0] pa, input logic [15:0] pb, input logic [15:0] pc, input logic rdy);
        int g;
        int st;
        logic [15:0] pr;
        logic [2:0] exp_rdy;
        @(negedge clk);
        fa_valid = v[0]; fb_valid = v[1]; fc_valid = v[2];
        fa_stock = sa; fb_stock = sb; fc_stock = sc;
        fa_price = pa; fb_price = pb; fc_price = pc;
        ord_ready = rdy;
        #1;
        g = -1;
        for (int i = 0; i < 3; i++) begin
            int e;
            e = (m_rr + i) % 3;
            if (g < 0 && v[e] == 1'b1) g = e;
        end
        exp_rdy = (g < 0) ? 3'b000 : (3'b001 << g);
        check_eq("ready", {fc_ready, fb_ready, fa_ready}, exp_rdy);
        check_eq("ord_valid", ord_valid, m_out);
        check_eq("ord_count", ord_count, 16'(m_count));
        if (m_out)
            check_eq("ord_fields", {ord_stock, ord_action_a, ord_action_b, ord_action_c}, {2'(m_sel), m_act});
        if (m_busy)
            check_eq("eng_out", {eng_stock_id, eng_price_a, eng_price_b, eng_price_c}, {2'(m_sel), m_snap});

        if (!m_busy) begin
            if (m_dirty != 0) begin
                for (int i = 0; i < 4; i++) begin
                    int s;
                    s = (m_sptr + i) % 4;
                    if (!m_busy && m_dirty[s]) begin
                        m_busy = 1'b1;
                        m_sel  = s;
                    end
                end
                m_dirty[m_sel] = 1'b0;
                m_snap = {m_price[m_sel][0], m_price[m_sel][1], m_price[m_sel][2]};
                m_age  = 1;
            end
        end else if (!m_out) begin
            if (m_age == LAT + 2) begin
                m_act = engine(m_snap[47:32], m_snap[31:16], m_snap[15:0]);
                if (m_act == 6'd0) begin
                    m_busy = 1'b0;
                    m_sptr = (m_sel + 1) % 4;
                end else begin
                    m_out = 1'b1;
                end
            end else begin
                m_age++;
            end
        end else if (rdy) begin
            if (m_count < 65535) m_count++;
            m_sptr = (m_sel + 1) % 4;
            m_out  = 1'b0;
            m_busy = 1'b0;
        end

        if (g >= 0) begin
            st = (g == 0) ? int'(sa) : (g == 1) ? int'(sb) : int'(sc);
            pr = (g == 0) ? pa : (g == 1) ? pb : pc;
            m_price[st][g] = pr;
            m_have[st][g]  = 1'b1;
            if (m_have[st][0] && m_have[st][1] && m_have[st][2]) m_dirty[st] = 1'b1;
            m_rr = (g + 1) % 3;
        end
    endtask

    task automatic quote(input int ex, input logic [1:0] s, input logic [15:0] p, input logic rdy);
        case (ex)
            0:       tick(3'b001, s, 2'd0, 2'd0, p, 16'd0, 16'd0, rdy);
            1:       tick(3'b010, 2'd0, s, 2'd0, 16'd0, p, 16'd0, rdy);
            default: tick(3'b100, 2'd0, 2'd0, s, 16'd0, 16'd0, p, rdy);
        endcase
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) tick(3'b000, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0, 16'd0, rdy);
    endtask

    initial begin
        model_reset();
        pulse_reset();

        // Stock 1: A=300 B=200 C=100 -> SELL/HOLD/BUY
        quote(0, 2'd1, 16'd300, 1'b1);
        quote(1, 2'd1, 16'd200, 1'b1);
        quote(2, 2'd1, 16'd100, 1'b1);
        idle(LAT + 6, 1'b1);
        check_eq("s1_count", ord_count, 16'd1);

        // All equal prices: evaluated, dropped, no order
        quote(0, 2'd0, 16'd100, 1'b1);
        quote(1, 2'd0, 16'd100, 1'b1);
        quote(2, 2'd0, 16'd100, 1'b1);
        idle(LAT + 6, 1'b1);
        check_eq("hold_count", ord_count, 16'd1);

        // Incomplete stock 2 stays unscheduled until C arrives
        quote(0, 2'd2, 16'd70, 1'b1);
        quote(1, 2'd2, 16'd60, 1'b1);
        idle(6, 1'b1);
        check_eq("partial_no_order", ord_valid, 1'b0);
        quote(2, 2'd2, 16'd50, 1'b1);
        idle(LAT + 6, 1'b1);
        check_eq("s2_count", ord_count, 16'd2);

        // All feeds valid for 6 cycles from a fresh pointer -> A,B,C,A,B,C
        pulse_reset();
        for (int i = 0; i < 6; i++)
            tick(3'b111, 2'd3, 2'd3, 2'd3, 16'($urandom_range(1, 500)),
                 16'($urandom_range(1, 500)), 16'($urandom_range(1, 500)), 1'b1);
        idle(2 * LAT + 12, 1'b1);

        // Back-pressure with a re-quote of the stock under evaluation
        pulse_reset();
        quote(0, 2'd3, 16'd10, 1'b0);
        quote(1, 2'd3, 16'd20, 1'b0);
        quote(2, 2'd3, 16'd30, 1'b0);
        idle(LAT + 4, 1'b0);
        check_eq("bp_valid", ord_valid, 1'b1);
        idle(3, 1'b0);
        quote(0, 2'd3, 16'd40, 1'b0);
        idle(6, 1'b0);
        idle(2 * LAT + 10, 1'b1);
        check_eq("bp_count", ord_count, 16'd2);

        // Reset during WAIT discards the in-flight evaluation and empties the table
        pulse_reset();
        quote(0, 2'd0, 16'd5, 1'b1);
        quote(1, 2'd0, 16'd6, 1'b1);
        quote(2, 2'd0, 16'd7, 1'b1);
        idle(3, 1'b1);
        pulse_reset();
        quote(2, 2'd0, 16'd9, 1'b1);
        idle(LAT + 6, 1'b1);
        check_eq("post_rst_no_order", ord_count, 16'd0);
        quote(0, 2'd0, 16'd1, 1'b1);
        quote(1, 2'd0, 16'd2, 1'b1);
        idle(LAT + 6, 1'b1);
        check_eq("post_rst_order", ord_count, 16'd1);

        // Random soak with a mid-run reset
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] v;
            v = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            if (n == 1500) pulse_reset();
            tick(v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 16'($urandom_range(98, 102)), 16'($urandom_range(98, 102)), 16'($urandom_range(98, 102)),
                 ($urandom_range(0, 3) != 0));
        end
        idle(2 * LAT + 12, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
